pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Sequences instruction fetch for the single-cycle core. Owns the PC register and issues one request per instruction to instruction memory over a req/ack handshake.
- Presents the fetched instruction to decode and holds it while the core stalls.
- Applies the taken-branch redirect (branch & zero) when the current instruction retires.
- Sits between imem and decode/execute. It replaces free-running PC update with a controlled fetch loop.

Parameters:
- RST_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
- Datapath width is `CPU_WIDTH from riscv_define.v. It is a global define, not a parameter.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- branch  input  1  decoded branch instruction; valid only while inst_vld=1.
- zero  input  1  ALU zero flag; valid only while inst_vld=1.
- pc_shift  input  `CPU_WIDTH  branch target (pc + imm).
- stall  input  1  core not ready to retire the current instruction.
- imem_ack  input  1  imem has accepted the request; imem_rdata is valid this cycle.
- imem_rdata  input  32  instruction word.
- imem_req  output  1  fetch request.
- imem_addr  output  `CPU_WIDTH  fetch address, equals pc.
- pc  output  `CPU_WIDTH  PC of the instruction being fetched or held.
- pc_add4  output  `CPU_WIDTH  pc + 4, wraps modulo 2^`CPU_WIDTH.
- inst  output  32  captured instruction.
- inst_vld  output  1  inst/pc valid for decode/execute.
- ret_cnt  output  32  retired-instruction counter.
- misalign_err  output  1  sticky misaligned-target error (optional feature).

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, pc=RST_PC, inst=0, inst_vld=0, imem_req=0, ret_cnt=0, misalign_err=0.
  - Reset overrides every state.
  - An outstanding request is abandoned: req drops at that edge, and any late ack is ignored.
- IDLE: imem_req=0. Advance to REQ on the next edge.
- REQ: imem_req=1, imem_addr=pc.
  - imem_ack=1 in the same cycle: capture imem_rdata into inst, set inst_vld=1, go to EXEC.
  - imem_ack=0: stay in REQ. req stays high and addr stays stable until ack.
- EXEC: inst_vld=1.
  - stall=1: hold state; pc, inst and inst_vld unchanged; imem_req=0.
  - stall=0 (retire): ret_cnt += 1 (wraps at 2^32), inst_vld cleared, go to REQ.
  - Next pc = pc_shift if (branch & zero), else pc_add4.
- branch, zero and pc_shift are sampled only in EXEC with stall=0. They are ignored in every other state.
- Throughput: minimum 2 cycles per instruction (REQ with zero-wait ack, then EXEC). Each extra ack wait cycle adds 1.
- pc_add4 is combinational from pc. The carry out of bit `CPU_WIDTH-1 is discarded, so 32'hFFFF_FFFC + 4 = 0.
- A stall asserted in REQ has no effect. Stall only gates retirement.
- imem_ack while imem_req=0 is ignored.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- Defined:
  - A taken redirect with pc_shift[1:0] != 2'b00 does not update pc or ret_cnt.
  - It sets misalign_err=1 (sticky until reset) and enters HALT.
  - HALT: imem_req=0, inst_vld=0, no exit except rst.
- Undefined:
  - No HALT state. The target is used with bits [1:0] forced to 2'b00.
  - misalign_err is tied to 0.

Decomposition:
- In riscv_define.v (shared include): FSM state encodings (IDLE/REQ/EXEC/HALT, 2-bit), the default RST_PC value, and the instruction width constant (32).
- One natural sub-module, pc_next_sel: the combinational next-PC select (pc_add4 vs pc_shift on branch & zero), plus alignment masking/check.
- The FSM, PC register and counter stay in pc_fetch_ctrl.

Test Plan:
- Reset then zero-wait ack, no branches, imem_rdata=32'h00000013 → imem_addr sequence 0, 4, 8 at one fetch per 2 cycles; ret_cnt=3 after 6 cycles past REQ entry.
- Ack delayed 3 cycles at pc=0x10 → imem_req held high with addr 0x10 for 4 cycles; inst_vld rises the cycle after ack.
- In EXEC at pc=0x20 with branch=1, zero=1, pc_shift=0x100, stall=0 → next imem_addr=0x100. Same with zero=0 → 0x24.
- stall=1 for 5 cycles in EXEC at pc=0x40 → inst/pc/inst_vld constant, imem_req=0, ret_cnt unchanged; released → imem_addr=0x44.
- rst asserted in REQ while waiting on ack → next cycle imem_req=0, pc=RST_PC; an ack arriving during IDLE is ignored; fetch restarts at RST_PC.
- PC_MISALIGN_CHK_EN defined, taken branch to 0x102 → misalign_err=1, HALT, no further req. Undefined → next imem_addr=0x100, misalign_err=0.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: FSM state encoding, default reset PC and
// instruction width. The datapath width comes from the global `CPU_WIDTH define; a fallback
// of 32 is provided here so the slice builds stand-alone.
//
// Optional feature macro used by the slice: PC_MISALIGN_CHK_EN.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

package pc_fetch_ctrl_pkg;

   localparam int unsigned INST_WIDTH = 32;

   localparam logic [`CPU_WIDTH-1:0] DEFAULT_RST_PC = '0;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StReq  = 2'b01,
      StExec = 2'b10,
      StHalt = 2'b11
   } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC select for the fetch controller.
//
// Ports:
//   take      - taken redirect (branch & zero)
//   pc_add4   - sequential successor of the current pc
//   pc_shift  - branch target (pc + imm)
//   next_pc   - selected next pc; a redirect target always has bits [1:0] cleared
//   misalign  - taken redirect whose raw target is not word aligned

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module pc_next_sel (
   input  logic                  take,
   input  logic [`CPU_WIDTH-1:0] pc_add4,
   input  logic [`CPU_WIDTH-1:0] pc_shift,
   output logic [`CPU_WIDTH-1:0] next_pc,
   output logic                  misalign
);

   always_comb begin
      next_pc  = pc_add4;
      misalign = 1'b0;
      if (take) begin
         next_pc  = {pc_shift[`CPU_WIDTH-1:2], 2'b00};
         misalign = (pc_shift[1:0] != 2'b00);
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one imem request per instruction over a
// req/ack handshake, holds the fetched instruction for decode while the core stalls, and
// applies the taken-branch redirect when the instruction retires.
//
// Optional feature macro: PC_MISALIGN_CHK_EN. When defined, a taken redirect to a target with
// non-zero low bits halts fetch and raises sticky misalign_err instead of retiring. When
// undefined the low target bits are dropped and misalign_err is tied low.
//
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   branch, zero        - redirect condition, sampled only when retiring
//   pc_shift            - redirect target
//   stall               - blocks retirement of the held instruction
//   imem_ack/imem_rdata - imem handshake response and instruction word
//   imem_req/imem_addr  - imem fetch request and address (== pc)
//   pc, pc_add4         - current pc and its wrapping successor
//   inst, inst_vld      - held instruction and its valid flag
//   ret_cnt             - retired-instruction counter (wraps)
//   misalign_err        - sticky misaligned-target error

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [`CPU_WIDTH-1:0] RST_PC = DEFAULT_RST_PC
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  branch,
   input  logic                  zero,
   input  logic [`CPU_WIDTH-1:0] pc_shift,
   input  logic                  stall,
   input  logic                  imem_ack,
   input  logic [INST_WIDTH-1:0] imem_rdata,
   output logic                  imem_req,
   output logic [`CPU_WIDTH-1:0] imem_addr,
   output logic [`CPU_WIDTH-1:0] pc,
   output logic [`CPU_WIDTH-1:0] pc_add4,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  inst_vld,
   output logic [31:0]           ret_cnt,
   output logic                  misalign_err
);

   localparam int unsigned W = `CPU_WIDTH;

   fetch_state_e          state_q, state_d;
   logic [W-1:0]          pc_q, pc_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic                  inst_vld_q, inst_vld_d;
   logic [31:0]           ret_cnt_q, ret_cnt_d;
   logic [W-1:0]          next_pc;
   logic                  misalign;

   assign pc_add4 = pc_q + W'(4);

   pc_next_sel u_pc_next_sel (
      .take     (branch & zero),
      .pc_add4  (pc_add4),
      .pc_shift (pc_shift),
      .next_pc  (next_pc),
      .misalign (misalign)
   );

`ifdef PC_MISALIGN_CHK_EN
   logic misalign_err_q, misalign_err_d;
   assign misalign_err = misalign_err_q;
`else
   logic unused_misalign;
   assign unused_misalign = misalign;
   assign misalign_err    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      inst_vld_d = inst_vld_q;
      ret_cnt_d  = ret_cnt_q;
      imem_req   = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
      misalign_err_d = misalign_err_q;
`endif
      unique case (state_q)
         StIdle: state_d = StReq;
         StReq: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               inst_d     = imem_rdata;
               inst_vld_d = 1'b1;
               state_d    = StExec;
            end
         end
         StExec: begin
            if (!stall) begin
`ifdef PC_MISALIGN_CHK_EN
               if (misalign) begin
                  // Faulting redirect never retires: pc and ret_cnt keep their values.
                  misalign_err_d = 1'b1;
                  inst_vld_d     = 1'b0;
                  state_d        = StHalt;
               end else
`endif
               begin
                  ret_cnt_d  = ret_cnt_q + 32'd1;
                  pc_d       = next_pc;
                  inst_vld_d = 1'b0;
                  state_d    = StReq;
               end
            end
         end
`ifdef PC_MISALIGN_CHK_EN
         StHalt: state_d = StHalt;
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pc_q       <= RST_PC;
         inst_q     <= '0;
         inst_vld_q <= 1'b0;
         ret_cnt_q  <= '0;
`ifdef PC_MISALIGN_CHK_EN
         misalign_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         inst_vld_q <= inst_vld_d;
         ret_cnt_q  <= ret_cnt_d;
`ifdef PC_MISALIGN_CHK_EN
         misalign_err_q <= misalign_err_d;
`endif
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign inst      = inst_q;
   assign inst_vld  = inst_vld_q;
   assign ret_cnt   = ret_cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl. Expected fetch addresses are pushed to a scoreboard
// queue when a retirement is driven and popped when the DUT raises its next request.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module tb_pc_fetch_ctrl;
   import pc_fetch_ctrl_pkg::*;

   localparam int W = `CPU_WIDTH;
   localparam logic [W-1:0] RST_VAL = '0;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst, branch, zero, stall, imem_ack;
   logic [W-1:0]  pc_shift;
   logic [31:0]   imem_rdata;
   logic          imem_req, inst_vld, misalign_err;
   logic [W-1:0]  imem_addr, pc, pc_add4;
   logic [31:0]   inst, ret_cnt;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  sb_q[$];
   logic [W-1:0]  model_pc;
   logic [31:0]   model_cnt;
   logic [31:0]   held_inst;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(.RST_PC(RST_VAL)) dut (
      .clk          (clk),
      .rst          (rst),
      .branch       (branch),
      .zero         (zero),
      .pc_shift     (pc_shift),
      .stall        (stall),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .pc           (pc),
      .pc_add4      (pc_add4),
      .inst         (inst),
      .inst_vld     (inst_vld),
      .ret_cnt      (ret_cnt),
      .misalign_err (misalign_err)
   );

   task automatic test_reset();
      rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;
      pc_shift = '0; imem_rdata = '0;
      @(negedge clk); @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || inst_vld !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: req=%b vld=%b want 0 0", imem_req, inst_vld);
      end
      checks++;
      if (pc !== RST_VAL || inst !== 32'd0 || ret_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_regs: pc=%h inst=%h cnt=%0d want %h 0 0", pc, inst, ret_cnt, RST_VAL);
      end
      checks++;
      if (misalign_err !== 1'b0) begin
         errors++; $display("FAIL reset_misalign: got %b want 0", misalign_err);
      end
      rst = 1'b0;
      sb_q.delete();
      sb_q.push_back(RST_VAL);
      model_pc  = RST_VAL;
      model_cnt = 0;
   endtask

   // Waits for a request, checks it against the scoreboard, holds ack off for wait_cyc cycles.
   task automatic do_fetch(input int wait_cyc, input logic [31:0] data);
      int n = 0;
      logic [W-1:0] exp;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (imem_req !== 1'b1) begin
         errors++; $display("FAIL fetch_timeout: req=%b want 1", imem_req);
         return;
      end
      if (sb_q.size() == 0) begin
         errors++; $display("FAIL sb_empty: request at %h with nothing expected", imem_addr);
         return;
      end
      exp = sb_q.pop_front();
      for (int i = 0; i < wait_cyc; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp || inst_vld !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: req=%b addr=%h vld=%b want 1 %h 0",
                     imem_req, imem_addr, inst_vld, exp);
         end
         @(negedge clk);
      end
      checks++;
      if (imem_addr !== exp || pc !== exp) begin
         errors++; $display("FAIL fetch_addr: addr=%h pc=%h want %h", imem_addr, pc, exp);
      end
      imem_ack = 1'b1; imem_rdata = data;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = 32'h0;
      checks++;
      if (inst_vld !== 1'b1 || inst !== data || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL fetch_capture: vld=%b inst=%h req=%b want 1 %h 0",
                  inst_vld, inst, imem_req, data);
      end
      held_inst = data;
      model_pc  = exp;
   endtask

   task automatic do_retire(input int stall_cyc, input logic br, input logic z,
                            input logic [W-1:0] shift, input logic junk_ack);
      logic [W-1:0] nxt;
      branch = br; zero = z; pc_shift = shift;
      for (int i = 0; i < stall_cyc; i++) begin
         stall = 1'b1;
         if (junk_ack) begin
            imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
         end
         @(negedge clk);
         checks++;
         if (inst_vld !== 1'b1 || pc !== model_pc || inst !== held_inst || imem_req !== 1'b0 ||
             ret_cnt !== model_cnt) begin
            errors++;
            $display("FAIL stall_hold: vld=%b pc=%h inst=%h req=%b cnt=%0d want 1 %h %h 0 %0d",
                     inst_vld, pc, inst, imem_req, ret_cnt, model_pc, held_inst, model_cnt);
         end
      end
      imem_ack = 1'b0; stall = 1'b0;
      checks++;
      if (pc_add4 !== model_pc + W'(4)) begin
         errors++; $display("FAIL pc_add4: got %h want %h", pc_add4, model_pc + W'(4));
      end
      nxt = (br && z) ? {shift[W-1:2], 2'b00} : model_pc + W'(4);
      sb_q.push_back(nxt);
      @(negedge clk);
      model_cnt++;
      branch = 1'b0; zero = 1'b0; pc_shift = '0;
      checks++;
      if (ret_cnt !== model_cnt || inst_vld !== 1'b0 || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL retire: cnt=%0d vld=%b req=%b want %0d 0 1",
                  ret_cnt, inst_vld, imem_req, model_cnt);
      end
      model_pc = nxt;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         do_fetch(0, NOP);
         do_retire(0, 1'b0, 1'b0, '0, 1'b0);
      end
      checks++;
      if (ret_cnt !== 32'd3 || imem_addr !== 32'hC) begin
         errors++; $display("FAIL seq_end: cnt=%0d addr=%h want 3 c", ret_cnt, imem_addr);
      end
   endtask

   task automatic test_ack_delay();
      do_fetch(0, NOP);
      do_retire(0, 1'b1, 1'b1, 32'h10, 1'b0);
      stall = 1'b1;  // stall while requesting must not matter
      do_fetch(3, 32'h0010_0093);
      do_retire(0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_branch();
      do_fetch(0, NOP);
      do_retire(0, 1'b1, 1'b1, 32'h20, 1'b0);
      do_fetch(0, NOP);
      do_retire(0, 1'b1, 1'b1, 32'h100, 1'b0);
      checks++;
      if (imem_addr !== 32'h100) begin
         errors++; $display("FAIL branch_taken: addr=%h want 100", imem_addr);
      end
      do_fetch(0, NOP);
      do_retire(0, 1'b1, 1'b1, 32'h20, 1'b0);
      do_fetch(0, NOP);
      do_retire(0, 1'b1, 1'b0, 32'h100, 1'b0);
      checks++;
      if (imem_addr !== 32'h24) begin
         errors++; $display("FAIL branch_not_taken: addr=%h want 24", imem_addr);
      end
   endtask

   task automatic test_stall();
      do_fetch(0, NOP);
      do_retire(0, 1'b1, 1'b1, 32'h40, 1'b0);
      do_fetch(0, 32'h0050_0093);
      do_retire(5, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (imem_addr !== 32'h44 || ret_cnt !== model_cnt) begin
         errors++; $display("FAIL stall_release: addr=%h cnt=%0d want 44 %0d",
                            imem_addr, ret_cnt, model_cnt);
      end
   endtask

   task automatic test_wrap();
      do_fetch(0, NOP);
      do_retire(0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
      do_fetch(0, NOP);
      checks++;
      if (pc_add4 !== 32'h0) begin
         errors++; $display("FAIL wrap_add4: got %h want 0", pc_add4);
      end
      do_retire(0, 1'b0, 1'b0, '0, 1'b0);
      do_fetch(0, NOP);
      do_retire(0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_reset_in_req();
      imem_ack = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
         errors++; $display("FAIL rreq_wait: req=%b addr=%h want 1 4", imem_req, imem_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || pc !== RST_VAL || ret_cnt !== 32'd0 || inst_vld !== 1'b0) begin
         errors++;
         $display("FAIL rreq_reset: req=%b pc=%h cnt=%0d vld=%b want 0 %h 0 0",
                  imem_req, pc, ret_cnt, inst_vld, RST_VAL);
      end
      rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;  // late ack lands in IDLE
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = 32'h0;
      checks++;
      if (inst_vld !== 1'b0 || inst !== 32'd0 || imem_req !== 1'b1 || imem_addr !== RST_VAL) begin
         errors++;
         $display("FAIL rreq_late_ack: vld=%b inst=%h req=%b addr=%h want 0 0 1 %h",
                  inst_vld, inst, imem_req, imem_addr, RST_VAL);
      end
      sb_q.delete();
      sb_q.push_back(RST_VAL);
      model_pc = RST_VAL; model_cnt = 0;
      do_fetch(0, NOP);
      do_retire(0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_misalign();
      do_fetch(0, NOP);
`ifdef PC_MISALIGN_CHK_EN
      stall = 1'b0; branch = 1'b1; zero = 1'b1; pc_shift = 32'h102;
      @(negedge clk);
      branch = 1'b0; zero = 1'b0; pc_shift = '0;
      checks++;
      if (misalign_err !== 1'b1 || inst_vld !== 1'b0 || pc !== model_pc ||
          ret_cnt !== model_cnt) begin
         errors++;
         $display("FAIL misalign_halt: err=%b vld=%b pc=%h cnt=%0d want 1 0 %h %0d",
                  misalign_err, inst_vld, pc, ret_cnt, model_pc, model_cnt);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b0 || misalign_err !== 1'b1) begin
            errors++; $display("FAIL misalign_stay: req=%b err=%b want 0 1",
                               imem_req, misalign_err);
         end
      end
`else
      do_retire(0, 1'b1, 1'b1, 32'h102, 1'b0);
      checks++;
      if (imem_addr !== 32'h100 || misalign_err !== 1'b0) begin
         errors++; $display("FAIL misalign_mask: addr=%h err=%b want 100 0",
                            imem_addr, misalign_err);
      end
      do_fetch(0, NOP);
`endif
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_ack_delay();
      test_branch();
      test_stall();
      test_wrap();
      test_reset_in_req();
      test_misalign();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
